// File: rtl/pipe_hazard_ctrl_if.sv
// rtl/pipe_hazard_ctrl_if.sv - hazard controller bundle between pipeline datapath and control
interface pipe_hazard_ctrl_if;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] writereg_e, writereg_m, writereg_w;
  logic       branch_d;
  logic       regwrite_e, regwrite_m, regwrite_w;
  logic       memtoreg_e, memtoreg_m;
  logic       div_start_e, dmem_wait, exc_m;
  logic       stall_f, stall_d, stall_e, stall_m;
  logic       flush_d, flush_e, flush_m, flush_w;
  logic [1:0] forward_a_e, forward_b_e;
  logic       div_busy, div_done;

  modport master (
    output rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w, branch_d,
           regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
           div_start_e, dmem_wait, exc_m,
    input  stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
           forward_a_e, forward_b_e, div_busy, div_done
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, writereg_e, writereg_m, writereg_w, branch_d,
           regwrite_e, regwrite_m, regwrite_w, memtoreg_e, memtoreg_m,
           div_start_e, dmem_wait, exc_m,
    output stall_f, stall_d, stall_e, stall_m, flush_d, flush_e, flush_m, flush_w,
           forward_a_e, forward_b_e, div_busy, div_done
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// rtl/pipe_hazard_ctrl.sv - 5-stage pipeline stall/flush/forward control with divide sequencer
// All freeze and bubble decisions for pc, F/D, D/E, E/M and M/W come from here.
module pipe_hazard_ctrl #(
  parameter int DIV_CYCLES = 32,
  parameter int CW         = 6
) (
  input logic          clk,
  input logic          reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t        state;
  logic [CW-1:0] cnt;

  logic lwstall, brstall, ld_hz, div_stall, mem_stall;

  // Register $0 is hardwired, so a zero destination never creates a dependency.
  function automatic logic dep(input logic [4:0] dst, input logic [4:0] src);
    return (dst != 5'd0) && (dst == src);
  endfunction

  function automatic logic [1:0] fwd_sel(input logic [4:0] src, input logic rw_m,
                                         input logic [4:0] wr_m, input logic rw_w,
                                         input logic [4:0] wr_w);
    if (rw_m && dep(wr_m, src))      return 2'b10;
    else if (rw_w && dep(wr_w, src)) return 2'b01;
    else                             return 2'b00;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else if (hz.exc_m) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: if (hz.div_start_e) begin
          state <= BUSY;
          cnt   <= CW'(DIV_CYCLES - 1);
        end
        BUSY: if (cnt == '0) state <= DONE;
              else           cnt   <= cnt - CW'(1);
        DONE: if (!hz.dmem_wait) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  assign lwstall = hz.memtoreg_e && hz.regwrite_e &&
                   (dep(hz.writereg_e, hz.rs_d) || dep(hz.writereg_e, hz.rt_d));
  assign brstall = hz.branch_d &&
                   ((hz.regwrite_e && (dep(hz.writereg_e, hz.rs_d) || dep(hz.writereg_e, hz.rt_d))) ||
                    (hz.memtoreg_m && (dep(hz.writereg_m, hz.rs_d) || dep(hz.writereg_m, hz.rt_d))));
  assign ld_hz     = lwstall || brstall;
  assign mem_stall = hz.dmem_wait;
  assign div_stall = (state == BUSY) || ((state == IDLE) && hz.div_start_e);

  assign hz.forward_a_e = fwd_sel(hz.rs_e, hz.regwrite_m, hz.writereg_m, hz.regwrite_w, hz.writereg_w);
  assign hz.forward_b_e = fwd_sel(hz.rt_e, hz.regwrite_m, hz.writereg_m, hz.regwrite_w, hz.writereg_w);
  assign hz.div_busy    = (state == BUSY);
  assign hz.div_done    = (state == DONE);

  // A bubble into a stage is dropped whenever a higher-priority cause is holding that stage.
  always_comb begin
    hz.stall_f = 1'b0;
    hz.stall_d = 1'b0;
    hz.stall_e = 1'b0;
    hz.stall_m = 1'b0;
    hz.flush_d = 1'b0;
    hz.flush_e = 1'b0;
    hz.flush_m = 1'b0;
    hz.flush_w = 1'b0;
    if (hz.exc_m) begin
      hz.flush_d = 1'b1;
      hz.flush_e = 1'b1;
      hz.flush_m = 1'b1;
      hz.flush_w = 1'b1;
    end else begin
      hz.stall_f = mem_stall || div_stall || ld_hz;
      hz.stall_d = mem_stall || div_stall || ld_hz;
      hz.stall_e = mem_stall || div_stall;
      hz.stall_m = mem_stall;
      hz.flush_w = mem_stall;
      hz.flush_m = div_stall && !mem_stall;
      hz.flush_e = ld_hz && !mem_stall && !div_stall;
    end
  end

endmodule
